// File: rtl/sensor_pwr_seq_if.sv
// Sensor power sequencer bus: power request, rail power-good and fault clear towards the
// sequencer; rail/INCK/XCLR controls, status and debug state back from it.
// The cfg_* delay signals exist only when SENSOR_PWR_SEQ_RUNTIME_DLY_EN is defined.
interface sensor_pwr_seq_if #(
    parameter int unsigned NUM_RAILS = 3
`ifdef SENSOR_PWR_SEQ_RUNTIME_DLY_EN
    ,
    parameter int unsigned DLY_W     = 20
`endif
);
    logic                 pwr_req_i;
    logic [NUM_RAILS-1:0] rail_pg_i;
    logic                 fault_clr_i;
`ifdef SENSOR_PWR_SEQ_RUNTIME_DLY_EN
    logic [DLY_W-1:0]     cfg_rail_dly_i;
    logic [DLY_W-1:0]     cfg_inck_dly_i;
    logic [DLY_W-1:0]     cfg_xclr_dly_i;
`endif
    logic [NUM_RAILS-1:0] reg_en_o;
    logic                 inck_en_o;
    logic                 xclr_o;
    logic                 ready_o;
    logic                 fault_o;
    logic [2:0]           fault_rail_o;
    logic [2:0]           state_o;

    // Controller side (CPU subsystem or bench).
    modport master (
        output pwr_req_i, rail_pg_i, fault_clr_i,
`ifdef SENSOR_PWR_SEQ_RUNTIME_DLY_EN
        output cfg_rail_dly_i, cfg_inck_dly_i, cfg_xclr_dly_i,
`endif
        input  reg_en_o, inck_en_o, xclr_o, ready_o, fault_o, fault_rail_o, state_o
    );

    // Sequencer side.
    modport slave (
        input  pwr_req_i, rail_pg_i, fault_clr_i,
`ifdef SENSOR_PWR_SEQ_RUNTIME_DLY_EN
        input  cfg_rail_dly_i, cfg_inck_dly_i, cfg_xclr_dly_i,
`endif
        output reg_en_o, inck_en_o, xclr_o, ready_o, fault_o, fault_rail_o, state_o
    );
endinterface

// File: rtl/sensor_pwr_seq.sv
// Image-sensor power sequencer: ordered rail / INCK / XCLR bring-up and tear-down, per-rail
// power-good timeout during bring-up, power-good monitoring while on, and a latched fault.
// Define SENSOR_PWR_SEQ_RUNTIME_DLY_EN to take the step delays from the cfg_* bus signals
// (captured when a power-up starts) instead of RAIL_DLY / INCK_DLY / XCLR_DLY.
module sensor_pwr_seq #(
    parameter int unsigned NUM_RAILS  = 3,
    parameter int unsigned DLY_W      = 20,
    parameter int unsigned RAIL_DLY   = 50000,
    parameter int unsigned INCK_DLY   = 5000,
    parameter int unsigned XCLR_DLY   = 5000,
    parameter int unsigned PG_TIMEOUT = 100000
) (
    input logic             clk_clk,
    input logic             reset_reset_n,
    sensor_pwr_seq_if.slave bus
);
    localparam int unsigned TMO_W = (PG_TIMEOUT > 0) ? $clog2(PG_TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TmoInit  = TMO_W'(PG_TIMEOUT);
    localparam logic [2:0]       LastRail = 3'(NUM_RAILS - 1);

    if (NUM_RAILS < 1 || NUM_RAILS > 8) begin : g_bad_rails
        $error("sensor_pwr_seq: NUM_RAILS must be 1..8");
    end
    if (DLY_W < 1 || DLY_W > 32) begin : g_bad_dly_w
        $error("sensor_pwr_seq: DLY_W must be 1..32");
    end
    if ((64'(RAIL_DLY) >> DLY_W) != 0 || (64'(INCK_DLY) >> DLY_W) != 0 ||
        (64'(XCLR_DLY) >> DLY_W) != 0) begin : g_bad_dly
        $error("sensor_pwr_seq: delay parameter does not fit in DLY_W bits");
    end

    typedef enum logic [3:0] {
        StOff, StRailUp, StInckWait, StXclrWait, StOn, StDownXclr, StDownInck, StRailDown, StFault
    } state_e;

    state_e               state_q, state_d;
    logic [DLY_W-1:0]     cnt_q, cnt_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [2:0]           idx_q, idx_d;
    logic [NUM_RAILS-1:0] reg_en_q, reg_en_d;
    logic                 inck_q, inck_d, xclr_q, xclr_d, ready_q, ready_d, fault_q, fault_d;
    logic [2:0]           fault_rail_q, fault_rail_d, state_code_q, state_code_d;
    logic                 pg_cur, pg_fail;
    logic [2:0]           fail_idx;
    logic [DLY_W-1:0]     rail_dly, inck_dly, xclr_dly, start_rail_dly;

`ifdef SENSOR_PWR_SEQ_RUNTIME_DLY_EN
    logic [DLY_W-1:0] rail_dly_q, inck_dly_q, xclr_dly_q;

    // Capture runtime delays at power-up start; they then govern both up and down sequences.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rail_dly_q <= '0;
            inck_dly_q <= '0;
            xclr_dly_q <= '0;
        end else if (state_q == StOff && state_d == StRailUp) begin
            rail_dly_q <= bus.cfg_rail_dly_i;
            inck_dly_q <= bus.cfg_inck_dly_i;
            xclr_dly_q <= bus.cfg_xclr_dly_i;
        end
    end

    assign start_rail_dly = bus.cfg_rail_dly_i;
    assign rail_dly       = rail_dly_q;
    assign inck_dly       = inck_dly_q;
    assign xclr_dly       = xclr_dly_q;
`else
    assign start_rail_dly = DLY_W'(RAIL_DLY);
    assign rail_dly       = DLY_W'(RAIL_DLY);
    assign inck_dly       = DLY_W'(INCK_DLY);
    assign xclr_dly       = DLY_W'(XCLR_DLY);
`endif

    // Power-good of the rail being brought up; lowest enabled rail that has lost power-good.
    always_comb begin
        pg_cur   = 1'b0;
        pg_fail  = 1'b0;
        fail_idx = '0;
        for (int k = NUM_RAILS - 1; k >= 0; k--) begin
            if (3'(k) == idx_q) pg_cur = bus.rail_pg_i[k];
            if (reg_en_q[k] && !bus.rail_pg_i[k]) begin
                pg_fail  = 1'b1;
                fail_idx = 3'(k);
            end
        end
    end

    // State, step counters and registered outputs.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= StOff;
            cnt_q        <= '0;
            tmo_q        <= '0;
            idx_q        <= '0;
            reg_en_q     <= '0;
            inck_q       <= 1'b0;
            xclr_q       <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
            fault_rail_q <= '0;
            state_code_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            idx_q        <= idx_d;
            reg_en_q     <= reg_en_d;
            inck_q       <= inck_d;
            xclr_q       <= xclr_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
            fault_rail_q <= fault_rail_d;
            state_code_q <= state_code_d;
        end
    end

    // Next state: a step exits on the first edge with the counter at zero and its condition met.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - DLY_W'(1) : cnt_q;
        tmo_d   = (tmo_q != '0) ? tmo_q - TMO_W'(1) : tmo_q;
        idx_d   = idx_q;
        unique case (state_q)
            StOff: begin
                if (bus.pwr_req_i) begin
                    state_d = StRailUp;
                    idx_d   = '0;
                    cnt_d   = start_rail_dly;
                    tmo_d   = TmoInit;
                end
            end
            StRailUp: begin
                if (!bus.pwr_req_i) begin
                    state_d = StDownXclr;
                    cnt_d   = xclr_dly;
                end else if (pg_cur && cnt_q == '0) begin
                    if (idx_q < LastRail) begin
                        idx_d = idx_q + 3'd1;
                        cnt_d = rail_dly;
                        tmo_d = TmoInit;
                    end else begin
                        state_d = StInckWait;
                        cnt_d   = inck_dly;
                    end
                end else if (!pg_cur && tmo_q == '0) begin
                    state_d = StFault;
                end
            end
            StInckWait, StXclrWait: begin
                if (!bus.pwr_req_i) begin
                    state_d = StDownXclr;
                    cnt_d   = xclr_dly;
                end else if (cnt_q == '0) begin
                    state_d = (state_q == StInckWait) ? StXclrWait : StOn;
                    cnt_d   = xclr_dly;
                end
            end
            StOn: begin
                if (pg_fail) begin
                    state_d = StFault;
                end else if (!bus.pwr_req_i) begin
                    state_d = StDownXclr;
                    cnt_d   = xclr_dly;
                end
            end
            StDownXclr: begin
                if (cnt_q == '0) begin
                    state_d = StDownInck;
                    cnt_d   = inck_dly;
                end
            end
            StDownInck: begin
                if (cnt_q == '0) begin
                    state_d = (NUM_RAILS == 1) ? StOff : StRailDown;
                    idx_d   = LastRail;
                    cnt_d   = rail_dly;
                end
            end
            StRailDown: begin
                // idx_q is the rail dropped last; step down to the next lower one.
                if (cnt_q == '0) begin
                    idx_d   = idx_q - 3'd1;
                    cnt_d   = rail_dly;
                    state_d = (idx_q == 3'd1) ? StOff : StRailDown;
                end
            end
            StFault: begin
                if (bus.fault_clr_i && !bus.pwr_req_i) state_d = StOff;
            end
            default: state_d = StOff;
        endcase
    end

    // Output next-values, derived from the transition being taken.
    always_comb begin
        reg_en_d     = reg_en_q;
        inck_d       = inck_q;
        xclr_d       = xclr_q;
        ready_d      = ready_q;
        fault_d      = fault_q;
        fault_rail_d = fault_rail_q;
        if (state_d == StFault && state_q != StFault) begin
            // Fault entry drops everything at once, no ordering.
            reg_en_d     = '0;
            inck_d       = 1'b0;
            xclr_d       = 1'b0;
            ready_d      = 1'b0;
            fault_d      = 1'b1;
            fault_rail_d = (state_q == StRailUp) ? idx_q : fail_idx;
        end else begin
            unique case (state_q)
                StOff: if (state_d == StRailUp) reg_en_d[0] = 1'b1;
                StRailUp: begin
                    if (state_d == StInckWait) inck_d = 1'b1;
                    if (state_d == StRailUp && idx_d != idx_q) begin
                        for (int k = 0; k < NUM_RAILS; k++) begin
                            if (3'(k) == idx_d) reg_en_d[k] = 1'b1;
                        end
                    end
                end
                StInckWait: if (state_d == StXclrWait) xclr_d = 1'b1;
                StXclrWait: if (state_d == StOn) ready_d = 1'b1;
                StDownXclr: if (state_d == StDownInck) inck_d = 1'b0;
                StDownInck: if (state_d != StDownInck) reg_en_d[NUM_RAILS-1] = 1'b0;
                StRailDown: begin
                    if (idx_d != idx_q) begin
                        for (int k = 0; k < NUM_RAILS; k++) begin
                            if (3'(k) == idx_d) reg_en_d[k] = 1'b0;
                        end
                    end
                end
                StFault: begin
                    if (state_d == StOff) begin
                        fault_d      = 1'b0;
                        fault_rail_d = '0;
                    end
                end
                default: ;
            endcase
            // Entering power-down (normal or abort) takes the sensor out of use immediately.
            if (state_d == StDownXclr && state_q != StDownXclr) begin
                xclr_d  = 1'b0;
                ready_d = 1'b0;
            end
        end
    end

    // Debug state code; both power-down rail phases (INCK wait and rail steps) report 6.
    always_comb begin
        state_code_d = 3'd0;
        unique case (state_d)
            StOff:                  state_code_d = 3'd0;
            StRailUp:               state_code_d = 3'd1;
            StInckWait:             state_code_d = 3'd2;
            StXclrWait:             state_code_d = 3'd3;
            StOn:                   state_code_d = 3'd4;
            StDownXclr:             state_code_d = 3'd5;
            StDownInck, StRailDown: state_code_d = 3'd6;
            StFault:                state_code_d = 3'd7;
            default:                state_code_d = 3'd0;
        endcase
    end

    assign bus.reg_en_o     = reg_en_q;
    assign bus.inck_en_o    = inck_q;
    assign bus.xclr_o       = xclr_q;
    assign bus.ready_o      = ready_q;
    assign bus.fault_o      = fault_q;
    assign bus.fault_rail_o = fault_rail_q;
    assign bus.state_o      = state_code_q;
endmodule

// File: tb/tb_sensor_pwr_seq.sv
// Bench for sensor_pwr_seq: directed stimulus pushes expected output events (cycle + full
// output snapshot) into a queue; a monitor pops one per observed output change and compares.
module tb_sensor_pwr_seq;
    localparam int unsigned NR = 3, DW = 8, RD = 10, ID = 5, XD = 8, TO = 20;

    typedef struct packed {
        logic [2:0] reg_en;
        logic       inck;
        logic       xclr;
        logic       ready;
        logic       fault;
        logic [2:0] frail;
        logic [2:0] st;
    } obs_t;

    typedef struct packed {
        logic [31:0] cyc;
        obs_t        v;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    ev_t         exp_q[$];
    ev_t         e;
    obs_t        cur;
    obs_t        prev = '0;
    logic [2:0]  pg_d1 = '0, pg_d2 = '0, pg_block = '0;
    int unsigned b, t, c;

`ifdef SENSOR_PWR_SEQ_RUNTIME_DLY_EN
    sensor_pwr_seq_if #(.NUM_RAILS(NR), .DLY_W(DW)) bus ();
    assign bus.cfg_rail_dly_i = DW'(RD);
    assign bus.cfg_inck_dly_i = DW'(ID);
    assign bus.cfg_xclr_dly_i = DW'(XD);
`else
    sensor_pwr_seq_if #(.NUM_RAILS(NR)) bus ();
`endif

    sensor_pwr_seq #(
        .NUM_RAILS (NR),
        .DLY_W     (DW),
        .RAIL_DLY  (RD),
        .INCK_DLY  (ID),
        .XCLR_DLY  (XD),
        .PG_TIMEOUT(TO)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Rail model: power-good follows the enable two cycles later, unless blocked.
    always @(posedge clk) begin
        pg_d1 <= bus.reg_en_o;
        pg_d2 <= pg_d1;
    end
    assign bus.rail_pg_i = pg_d2 & ~pg_block;

    assign cur = {bus.reg_en_o, bus.inck_en_o, bus.xclr_o, bus.ready_o, bus.fault_o,
                  bus.fault_rail_o, bus.state_o};

    function automatic string fmt(input obs_t o);
        return $sformatf("re=%b inck=%b xclr=%b rdy=%b flt=%b frail=%0d st=%0d",
                         o.reg_en, o.inck, o.xclr, o.ready, o.fault, o.frail, o.st);
    endfunction

    // Monitor: every output change must match the next expected event, cycle included.
    always @(negedge clk) begin
        if (cur != prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc %0d got %s", cyc, fmt(cur));
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.v != cur) begin
                    errors++;
                    $display("FAIL event got cyc %0d %s, want cyc %0d %s",
                             cyc, fmt(cur), e.cyc, fmt(e.v));
                end
            end
        end
        prev <= cur;
    end

    task automatic ev(input int unsigned cy, input logic [2:0] re, input logic inck,
                      input logic xclr, input logic rdy, input logic flt,
                      input logic [2:0] frail, input logic [2:0] st);
        ev_t x;
        x.cyc = cy;
        x.v   = {re, inck, xclr, rdy, flt, frail, st};
        exp_q.push_back(x);
    endtask

    // Full power-up with pwr_req_i first sampled high at edge bb+1.
    task automatic push_up(input int unsigned bb);
        ev(bb + 1,  3'b001, 0, 0, 0, 0, 0, 1);
        ev(bb + 12, 3'b011, 0, 0, 0, 0, 0, 1);
        ev(bb + 23, 3'b111, 0, 0, 0, 0, 0, 1);
        ev(bb + 34, 3'b111, 1, 0, 0, 0, 0, 2);
        ev(bb + 40, 3'b111, 1, 1, 0, 0, 0, 3);
        ev(bb + 49, 3'b111, 1, 1, 1, 0, 0, 4);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int unsigned cy);
        while (cyc < cy) step(1);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        bus.pwr_req_i   = 1'b0;
        bus.fault_clr_i = 1'b0;
        #1 rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        chk("reset_outputs", 32'(cur), 32'd0);
        step(2);

        // Power-up.
        b = cyc;
        push_up(b);
        bus.pwr_req_i = 1'b1;
        run_to(b + 55);
        chk("on_ready", 32'(bus.ready_o), 32'd1);

        // Power-down from ON.
        t = cyc + 1;
        bus.pwr_req_i = 1'b0;
        ev(t,      3'b111, 1, 0, 0, 0, 0, 5);
        ev(t + 9,  3'b111, 0, 0, 0, 0, 0, 6);
        ev(t + 15, 3'b011, 0, 0, 0, 0, 0, 6);
        ev(t + 26, 3'b001, 0, 0, 0, 0, 0, 6);
        ev(t + 37, 3'b000, 0, 0, 0, 0, 0, 0);
        run_to(t + 40);
        chk("down_state_off", 32'(bus.state_o), 32'd0);

        // Power-good timeout on rail 1.
        pg_block = 3'b010;
        b = cyc;
        ev(b + 1,  3'b001, 0, 0, 0, 0, 0, 1);
        ev(b + 12, 3'b011, 0, 0, 0, 0, 0, 1);
        ev(b + 33, 3'b000, 0, 0, 0, 1, 1, 7);
        bus.pwr_req_i = 1'b1;
        run_to(b + 40);
        chk("tmo_fault_rail", 32'(bus.fault_rail_o), 32'd1);
        c = cyc;
        bus.pwr_req_i   = 1'b0;
        bus.fault_clr_i = 1'b1;
        ev(c + 1, 3'b000, 0, 0, 0, 0, 0, 0);
        step(1);
        bus.fault_clr_i = 1'b0;
        pg_block = 3'b000;
        step(3);

        // Power-good loss in ON, clear ignored while pwr_req_i is high.
        b = cyc;
        push_up(b);
        bus.pwr_req_i = 1'b1;
        run_to(b + 55);
        c = cyc;
        pg_block = 3'b100;
        ev(c + 1, 3'b000, 0, 0, 0, 1, 2, 7);
        step(3);
        bus.fault_clr_i = 1'b1;
        step(3);
        chk("clr_ignored_fault", 32'(bus.fault_o), 32'd1);
        chk("clr_ignored_rail", 32'(bus.fault_rail_o), 32'd2);
        c = cyc;
        bus.pwr_req_i = 1'b0;
        ev(c + 1, 3'b000, 0, 0, 0, 0, 0, 0);
        step(1);
        bus.fault_clr_i = 1'b0;
        pg_block = 3'b000;
        step(3);
        chk("clr_fault_low", 32'(bus.fault_o), 32'd0);

        // Abort during rail-up; a request during power-down waits for OFF then restarts.
        b = cyc;
        bus.pwr_req_i = 1'b1;
        ev(b + 1,  3'b001, 0, 0, 0, 0, 0, 1);
        ev(b + 12, 3'b011, 0, 0, 0, 0, 0, 1);
        step(14);
        t = b + 15;
        bus.pwr_req_i = 1'b0;
        ev(t,      3'b011, 0, 0, 0, 0, 0, 5);
        ev(t + 9,  3'b011, 0, 0, 0, 0, 0, 6);
        ev(t + 26, 3'b001, 0, 0, 0, 0, 0, 6);
        ev(t + 37, 3'b000, 0, 0, 0, 0, 0, 0);
        push_up(t + 37);
        step(5);
        bus.pwr_req_i = 1'b1;
        run_to(t + 37 + 55);

        // Asynchronous reset while ON, then power-up again.
        #2 rst_n = 1'b0;
        c = cyc;
        ev(c, 3'b000, 0, 0, 0, 0, 0, 0);
        #1;
        chk("async_reg_en", 32'(bus.reg_en_o), 32'd0);
        chk("async_inck", 32'(bus.inck_en_o), 32'd0);
        chk("async_xclr", 32'(bus.xclr_o), 32'd0);
        chk("async_ready", 32'(bus.ready_o), 32'd0);
        step(3);
        #2 rst_n = 1'b1;
        b = cyc;
        push_up(b);
        run_to(b + 55);

        step(3);
        chk("events_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
